// File: rtl/axistream_snooper_pkg.sv
// -----------------------------------------------------------------------------
// axistream_snooper_pkg
// Shared definitions for the stream snooper and the forwarder that will follow
// it. Holds the CLOG2 helper, the width derivations used by the snooper's
// write port, the default sizes and the state encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
`ifndef AXISTREAM_SNOOPER_CLOG2_DEFINED
`define AXISTREAM_SNOOPER_CLOG2_DEFINED
`define CLOG2(x) $clog2(x)
`endif

package axistream_snooper_pkg;

  localparam int DEF_SN_FWD_DATA_WIDTH = 64;
  localparam int DEF_PACKET_MEM_BYTES  = 2048;

  // Word address width: buffer bytes divided by bytes per stream word.
  function automatic int sn_addr_width(input int data_width, input int mem_bytes);
    return `CLOG2(mem_bytes) - `CLOG2(data_width / 8);
  endfunction

  // The increment must be able to hold a full word's byte count, hence +1.
  function automatic int sn_inc_width(input int data_width);
    return `CLOG2(data_width / 8) + 1;
  endfunction

  localparam int DEF_SN_FWD_ADDR_WIDTH = sn_addr_width(DEF_SN_FWD_DATA_WIDTH, DEF_PACKET_MEM_BYTES);
  localparam int DEF_INC_WIDTH         = sn_inc_width(DEF_SN_FWD_DATA_WIDTH);

  // Encoding is fixed so the forwarder can decode the same state values.
  typedef enum logic [1:0] {
    SN_RESYNC   = 2'd0,
    SN_IDLE     = 2'd1,
    SN_WRITING  = 2'd2,
    SN_DROPPING = 2'd3
  } sn_state_t;

endpackage

// File: rtl/axistream_snooper_keep_popcount.sv
// -----------------------------------------------------------------------------
// keep_popcount
// Combinational count of set bits in a TKEEP vector, giving the number of
// valid bytes in a beat.
// Ports:
//   keep   in   KEEP_WIDTH  byte enables
//   count  out  CNT_WIDTH   number of enabled bytes
// -----------------------------------------------------------------------------
module keep_popcount #(
  parameter int KEEP_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [CNT_WIDTH-1:0]  count
);

  // A full popcount rather than a leading-one search, so a malformed
  // non-contiguous TKEEP still reports the true number of enabled bytes.
  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      count = count + CNT_WIDTH'(keep[i]);
    end
  end

endmodule

// File: rtl/axistream_snooper.sv
// -----------------------------------------------------------------------------
// axistream_snooper
// Passively watches an AXI-Stream bus (never drives TREADY), claims a free
// packet buffer from the core, and copies each packet beat into packet memory.
// Packets arriving with no free buffer are dropped whole and counted.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   snoop_T*        observed stream (TDATA/TKEEP/TLAST/TVALID/TREADY)
//   sn_addr         registered word write address
//   sn_wr_data      registered write data
//   sn_wr_en        registered write strobe
//   sn_byte_inc     valid bytes in the current write, 0 when not writing
//   sn_done         one-cycle end-of-packet pulse
//   rdy_for_sn      core has a free buffer (sampled only between packets)
//   rdy_for_sn_ack  one-cycle buffer claim
//   pkt_drop_cnt    wrapping count of dropped packets
// -----------------------------------------------------------------------------
module axistream_snooper
  import axistream_snooper_pkg::*;
#(
  parameter int SN_FWD_DATA_WIDTH = DEF_SN_FWD_DATA_WIDTH,
  parameter int PACKET_MEM_BYTES  = DEF_PACKET_MEM_BYTES,
  parameter int RESYNC_ON_RST     = 1,
  localparam int SN_FWD_ADDR_WIDTH = sn_addr_width(SN_FWD_DATA_WIDTH, PACKET_MEM_BYTES),
  localparam int INC_WIDTH         = sn_inc_width(SN_FWD_DATA_WIDTH),
  localparam int KEEP_WIDTH        = SN_FWD_DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SN_FWD_DATA_WIDTH-1:0] snoop_TDATA,
  input  logic [KEEP_WIDTH-1:0]        snoop_TKEEP,
  input  logic                         snoop_TLAST,
  input  logic                         snoop_TVALID,
  input  logic                         snoop_TREADY,
  output logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr,
  output logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
  output logic                         sn_wr_en,
  output logic [INC_WIDTH-1:0]         sn_byte_inc,
  output logic                         sn_done,
  input  logic                         rdy_for_sn,
  output logic                         rdy_for_sn_ack,
  output logic [31:0]                  pkt_drop_cnt
);

  localparam logic [SN_FWD_ADDR_WIDTH-1:0] ADDR_MAX = '1;

  sn_state_t                    state_q, state_d;
  logic [SN_FWD_ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                         full_q, full_d;
  logic [SN_FWD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SN_FWD_DATA_WIDTH-1:0] data_q, data_d;
  logic                         wr_en_q, wr_en_d;
  logic [INC_WIDTH-1:0]         inc_q, inc_d;
  logic                         done_q, done_d;
  logic                         ack_q, ack_d;
  logic [31:0]                  drop_q, drop_d;

  logic                         beat;
  logic [INC_WIDTH-1:0]         keep_bytes;

  assign beat = snoop_TVALID & snoop_TREADY;

  keep_popcount #(
    .KEEP_WIDTH (KEEP_WIDTH),
    .CNT_WIDTH  (INC_WIDTH)
  ) u_keep_popcount (
    .keep  (snoop_TKEEP),
    .count (keep_bytes)
  );

  // Next-state and next-output logic. Strobes default low every cycle; the
  // address and data registers hold unless a write is issued.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    full_d     = full_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    inc_d      = '0;
    done_d     = 1'b0;
    ack_d      = 1'b0;
    drop_d     = drop_q;

    case (state_q)
      SN_RESYNC: begin
        // Traffic seen right after reset may be a packet tail; wait for a
        // TLAST so the next beat is known to be a packet start.
        if (beat && snoop_TLAST) begin
          state_d = SN_IDLE;
        end
      end

      SN_IDLE: begin
        if (beat) begin
          if (rdy_for_sn) begin
            ack_d      = 1'b1;
            wr_en_d    = 1'b1;
            addr_d     = '0;
            data_d     = snoop_TDATA;
            inc_d      = keep_bytes;
            word_cnt_d = SN_FWD_ADDR_WIDTH'(1);
            full_d     = 1'b0;
            if (snoop_TLAST) begin
              done_d = 1'b1;
            end else begin
              state_d = SN_WRITING;
            end
          end else begin
            drop_d = drop_q + 32'd1;
            if (!snoop_TLAST) begin
              state_d = SN_DROPPING;
            end
          end
        end
      end

      SN_WRITING: begin
        if (beat) begin
          // Once the last word is written the counter parks and further
          // beats are discarded rather than wrapping over the packet start.
          if (!full_q) begin
            wr_en_d = 1'b1;
            addr_d  = word_cnt_q;
            data_d  = snoop_TDATA;
            inc_d   = keep_bytes;
            if (word_cnt_q == ADDR_MAX) begin
              full_d = 1'b1;
            end else begin
              word_cnt_d = word_cnt_q + SN_FWD_ADDR_WIDTH'(1);
            end
          end
          if (snoop_TLAST) begin
            done_d  = 1'b1;
            full_d  = 1'b0;
            state_d = SN_IDLE;
          end
        end
      end

      SN_DROPPING: begin
        if (beat && snoop_TLAST) begin
          state_d = SN_IDLE;
        end
      end

      default: state_d = SN_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (RESYNC_ON_RST != 0) ? SN_RESYNC : SN_IDLE;
      word_cnt_q <= '0;
      full_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
      inc_q      <= '0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      full_q     <= full_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
      inc_q      <= inc_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      drop_q     <= drop_d;
    end
  end

  assign sn_addr        = addr_q;
  assign sn_wr_data     = data_q;
  assign sn_wr_en       = wr_en_q;
  assign sn_byte_inc    = inc_q;
  assign sn_done        = done_q;
  assign rdy_for_sn_ack = ack_q;
  assign pkt_drop_cnt   = drop_q;

endmodule

// File: tb/tb_axistream_snooper.sv
// -----------------------------------------------------------------------------
// tb_axistream_snooper
// Directed bench for axistream_snooper at default parameters (64-bit data,
// 256-word buffer, resync after reset). Expected write-port events are queued
// with the cycle they must appear in; a monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_axistream_snooper;

  typedef struct {
    int          cyc;
    logic        wr_en;
    logic        ack;
    logic        done;
    logic [7:0]  addr;
    logic [63:0] data;
    logic [3:0]  inc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [63:0] snoop_TDATA;
  logic [7:0]  snoop_TKEEP;
  logic        snoop_TLAST;
  logic        snoop_TVALID;
  logic        snoop_TREADY;
  logic [7:0]  sn_addr;
  logic [63:0] sn_wr_data;
  logic        sn_wr_en;
  logic [3:0]  sn_byte_inc;
  logic        sn_done;
  logic        rdy_for_sn;
  logic        rdy_for_sn_ack;
  logic [31:0] pkt_drop_cnt;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  axistream_snooper dut (
    .clk            (clk),
    .rst            (rst),
    .snoop_TDATA    (snoop_TDATA),
    .snoop_TKEEP    (snoop_TKEEP),
    .snoop_TLAST    (snoop_TLAST),
    .snoop_TVALID   (snoop_TVALID),
    .snoop_TREADY   (snoop_TREADY),
    .sn_addr        (sn_addr),
    .sn_wr_data     (sn_wr_data),
    .sn_wr_en       (sn_wr_en),
    .sn_byte_inc    (sn_byte_inc),
    .sn_done        (sn_done),
    .rdy_for_sn     (rdy_for_sn),
    .rdy_for_sn_ack (rdy_for_sn_ack),
    .pkt_drop_cnt   (pkt_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp: increments on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Queue an event expected in the cycle after the beat about to be applied.
  task automatic expectEvent(input logic wr, input logic ack, input logic done,
                             input logic [7:0] addr, input logic [63:0] data,
                             input logic [3:0] inc);
    exp_t e;
    e.cyc   = cyc + 1;
    e.wr_en = wr;
    e.ack   = ack;
    e.done  = done;
    e.addr  = addr;
    e.data  = data;
    e.inc   = inc;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stream inputs, then step just past the rising edge.
  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k,
                               input logic l, input logic v, input logic r);
    snoop_TDATA  = d;
    snoop_TKEEP  = k;
    snoop_TLAST  = l;
    snoop_TVALID = v;
    snoop_TREADY = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(64'h0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: at each falling edge, retire stale expectations, then compare
  // the DUT's strobes against the event due this cycle (if any).
  always @(negedge clk) begin
    exp_t e;
    logic active;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_event: expected at cycle %0d, got none (now %0d)", exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    active = sn_wr_en | sn_done | rdy_for_sn_ack;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      vectors++;
      if (sn_wr_en !== e.wr_en || rdy_for_sn_ack !== e.ack || sn_done !== e.done ||
          sn_byte_inc !== e.inc ||
          (e.wr_en && (sn_addr !== e.addr || sn_wr_data !== e.data))) begin
        miscompares++;
        $display("[TB] FAIL event cyc %0d: got wr=%b ack=%b done=%b addr=%0d inc=%0d data=%h, expected wr=%b ack=%b done=%b addr=%0d inc=%0d data=%h",
                 cyc, sn_wr_en, rdy_for_sn_ack, sn_done, sn_addr, sn_byte_inc, sn_wr_data,
                 e.wr_en, e.ack, e.done, e.addr, e.inc, e.data);
      end
    end else if (active) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected_event cyc %0d: got wr=%b ack=%b done=%b addr=%0d, expected no event",
               cyc, sn_wr_en, rdy_for_sn_ack, sn_done, sn_addr);
    end else if (sn_byte_inc !== 4'd0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL idle_byte_inc cyc %0d: got %0d, expected 0", cyc, sn_byte_inc);
    end
  end

  initial begin
    logic [63:0] d;
    rst          = 1'b1;
    rdy_for_sn   = 1'b0;
    snoop_TDATA  = '0;
    snoop_TKEEP  = '0;
    snoop_TLAST  = 1'b0;
    snoop_TVALID = 1'b0;
    snoop_TREADY = 1'b0;
    idleCycles(3);
    rst = 1'b0;

    // Reset state
    checkOutput("rst_wr_en", 64'(sn_wr_en), 64'd0);
    checkOutput("rst_done", 64'(sn_done), 64'd0);
    checkOutput("rst_ack", 64'(rdy_for_sn_ack), 64'd0);
    checkOutput("rst_addr", 64'(sn_addr), 64'd0);
    checkOutput("rst_data", sn_wr_data, 64'd0);
    checkOutput("rst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);

    // Packet straight after reset is swallowed by resync, not dropped
    rdy_for_sn = 1'b1;
    applyStimulus(64'h1111_1111_1111_1111, 8'hFF, 1'b1, 1'b1, 1'b1);
    idleCycles(1);
    checkOutput("resync_drop_cnt", 64'(pkt_drop_cnt), 64'd0);

    // Three-beat packet, short last beat
    expectEvent(1'b1, 1'b1, 1'b0, 8'd0, 64'hB0B0_0000_0000_0000, 4'd8);
    applyStimulus(64'hB0B0_0000_0000_0000, 8'hFF, 1'b0, 1'b1, 1'b1);
    expectEvent(1'b1, 1'b0, 1'b0, 8'd1, 64'hB1B1_0000_0000_0001, 4'd8);
    applyStimulus(64'hB1B1_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 1'b1);
    expectEvent(1'b1, 1'b0, 1'b1, 8'd2, 64'h0000_0000_B2B2_B2B2, 4'd4);
    applyStimulus(64'h0000_0000_B2B2_B2B2, 8'h0F, 1'b1, 1'b1, 1'b1);
    idleCycles(2);

    // No free buffer: four-beat packet dropped whole
    rdy_for_sn = 1'b0;
    checkOutput("drop_cnt_before", 64'(pkt_drop_cnt), 64'd0);
    applyStimulus(64'hC0, 8'hFF, 1'b0, 1'b1, 1'b1);
    checkOutput("drop_cnt_first_beat", 64'(pkt_drop_cnt), 64'd1);
    applyStimulus(64'hC1, 8'hFF, 1'b0, 1'b1, 1'b1);
    rdy_for_sn = 1'b1;
    applyStimulus(64'hC2, 8'hFF, 1'b0, 1'b1, 1'b1);
    applyStimulus(64'hC3, 8'hFF, 1'b1, 1'b1, 1'b1);
    idleCycles(1);
    checkOutput("drop_cnt_after", 64'(pkt_drop_cnt), 64'd1);

    // Following packet starts at address 0; a TVALID-without-TREADY cycle is not a beat
    expectEvent(1'b1, 1'b1, 1'b0, 8'd0, 64'hCC00, 4'd8);
    applyStimulus(64'hCC00, 8'hFF, 1'b0, 1'b1, 1'b1);
    applyStimulus(64'hDEAD, 8'hFF, 1'b1, 1'b1, 1'b0);
    expectEvent(1'b1, 1'b0, 1'b1, 8'd1, 64'hCC01, 4'd6);
    applyStimulus(64'hCC01, 8'h3F, 1'b1, 1'b1, 1'b1);
    idleCycles(2);

    // 300-beat packet overflows the 256-word buffer
    for (int i = 0; i < 300; i++) begin
      d = {32'hD000_0000, 32'(i)};
      if (i < 256) expectEvent(1'b1, (i == 0), 1'b0, 8'(i), d, 4'd8);
      else if (i == 299) expectEvent(1'b0, 1'b0, 1'b1, 8'd0, 64'd0, 4'd0);
      applyStimulus(d, 8'hFF, (i == 299), 1'b1, 1'b1);
    end
    idleCycles(2);

    // Back-to-back packets with no gap
    expectEvent(1'b1, 1'b1, 1'b0, 8'd0, 64'hE0, 4'd8);
    applyStimulus(64'hE0, 8'hFF, 1'b0, 1'b1, 1'b1);
    expectEvent(1'b1, 1'b0, 1'b1, 8'd1, 64'hE1, 4'd2);
    applyStimulus(64'hE1, 8'h03, 1'b1, 1'b1, 1'b1);
    expectEvent(1'b1, 1'b1, 1'b1, 8'd0, 64'hE2, 4'd8);
    applyStimulus(64'hE2, 8'hFF, 1'b1, 1'b1, 1'b1);
    idleCycles(2);

    // Reset on beat 2 of 5: outputs clear, rest of packet ignored
    expectEvent(1'b1, 1'b1, 1'b0, 8'd0, 64'hF0, 4'd8);
    applyStimulus(64'hF0, 8'hFF, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    applyStimulus(64'hF1, 8'hFF, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    checkOutput("midrst_wr_en", 64'(sn_wr_en), 64'd0);
    checkOutput("midrst_ack", 64'(rdy_for_sn_ack), 64'd0);
    checkOutput("midrst_data", sn_wr_data, 64'd0);
    checkOutput("midrst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
    applyStimulus(64'hF2, 8'hFF, 1'b0, 1'b1, 1'b1);
    applyStimulus(64'hF3, 8'hFF, 1'b0, 1'b1, 1'b1);
    applyStimulus(64'hF4, 8'hFF, 1'b1, 1'b1, 1'b1);
    expectEvent(1'b1, 1'b1, 1'b1, 8'd0, 64'hF5, 4'd1);
    applyStimulus(64'hF5, 8'h01, 1'b1, 1'b1, 1'b1);
    idleCycles(3);

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
